// File: rtl/throttle_pkg.sv
// rtl/throttle_pkg.sv - shared defaults, level/step types and divider half-period helper for throttle_ctrl
package throttle_pkg;

    localparam int DEF_NUM_LEVELS = 8;
    localparam int DEF_LEVEL_W    = 3;
    localparam int DEF_MAX_SHIFT  = 24;

    typedef logic [DEF_LEVEL_W-1:0] level_t;

    // Encoded as {dn, up} so the two debounced pulses map straight onto a command.
    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_UP   = 2'b01,
        STEP_DN   = 2'b10,
        STEP_BOTH = 2'b11
    } step_e;

    function automatic logic [31:0] half_period(input int unsigned max_shift,
                                                input int unsigned level);
        return 32'd1 << (max_shift - level);
    endfunction

endpackage

// File: rtl/pb_debounce.sv
// rtl/pb_debounce.sv - pushbutton sync, debounce and press pulse; autorepeat when THROTTLE_AUTOREPEAT_EN is defined
module pb_debounce
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_i,
    output logic step_o
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            armed_q;
    logic            armed_d;
    logic            accepted_q;
    logic            accepted_d;
    logic            accepted_prev_q;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            step_q;
    logic            step_d;
    logic            progress;
    logic            rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pb_i;
            sync2_q <= sync1_q;
        end
    end

    // Until a stable release is seen after reset the counter qualifies lows only,
    // so a button held through reset never produces a press.
    always_comb begin
        progress   = armed_q ? (sync2_q != accepted_q) : !sync2_q;
        db_cnt_d   = '0;
        accepted_d = accepted_q;
        armed_d    = armed_q;
        if (progress) begin
            if (db_cnt_q == DB_LAST) begin
                if (armed_q) begin
                    accepted_d = sync2_q;
                end else begin
                    armed_d = 1'b1;
                end
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    assign rise = accepted_q & ~accepted_prev_q;

`ifdef THROTTLE_AUTOREPEAT_EN
    localparam int RP_W = $clog2((HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES) + 1);

    logic [RP_W-1:0] rp_cnt_q;
    logic [RP_W-1:0] rp_cnt_d;
    logic            repeating_q;
    logic            repeating_d;

    // Counter holds cycles since the last emitted pulse; the first gap is the hold delay.
    always_comb begin
        step_d      = 1'b0;
        rp_cnt_d    = '0;
        repeating_d = 1'b0;
        if (rise) begin
            step_d   = 1'b1;
            rp_cnt_d = RP_W'(1);
        end else if (accepted_q) begin
            repeating_d = repeating_q;
            rp_cnt_d    = rp_cnt_q + RP_W'(1);
            if (rp_cnt_q == (repeating_q ? RP_W'(REPEAT_CYCLES) : RP_W'(HOLD_CYCLES))) begin
                step_d      = 1'b1;
                rp_cnt_d    = RP_W'(1);
                repeating_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp_cnt_q    <= '0;
            repeating_q <= 1'b0;
        end else begin
            rp_cnt_q    <= rp_cnt_d;
            repeating_q <= repeating_d;
        end
    end
`else
    localparam int unused_repeat_cfg = HOLD_CYCLES + REPEAT_CYCLES;

    always_comb begin
        step_d = rise;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q         <= 1'b0;
            accepted_q      <= 1'b0;
            accepted_prev_q <= 1'b0;
            db_cnt_q        <= '0;
            step_q          <= 1'b0;
        end else begin
            armed_q         <= armed_d;
            accepted_q      <= accepted_d;
            accepted_prev_q <= accepted_q;
            db_cnt_q        <= db_cnt_d;
            step_q          <= step_d;
        end
    end

    assign step_o = step_q;

endmodule

// File: rtl/throttle_ctrl.sv
// rtl/throttle_ctrl.sv - button-driven saturating rate level and glitch-free slow clock divider (option: THROTTLE_AUTOREPEAT_EN)
module throttle_ctrl
    import throttle_pkg::*;
#(
    parameter int NUM_LEVELS      = DEF_NUM_LEVELS,
    parameter int LEVEL_W         = DEF_LEVEL_W,
    parameter int MAX_SHIFT       = DEF_MAX_SHIFT,
    parameter int RESET_LEVEL     = 0,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic               CLK_50,
    input  logic               reset,
    input  logic               pb_freq_up,
    input  logic               pb_freq_dn,
    output logic               slow_clk,
    output logic               slow_tick,
    output logic [LEVEL_W-1:0] freq_num,
    output logic               at_max,
    output logic               at_min
);

    localparam int                 CNT_W      = MAX_SHIFT + 1;
    localparam logic [LEVEL_W-1:0] TOP_LEVEL  = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [LEVEL_W-1:0] INIT_LEVEL = LEVEL_W'(RESET_LEVEL);

    logic               up_step;
    logic               dn_step;
    step_e              step;
    logic [LEVEL_W-1:0] freq_num_q;
    logic [LEVEL_W-1:0] freq_num_d;
    logic [LEVEL_W-1:0] active_level_q;
    logic [LEVEL_W-1:0] active_level_d;
    logic [CNT_W-1:0]   div_cnt_q;
    logic [CNT_W-1:0]   div_cnt_d;
    logic [CNT_W-1:0]   half_m1;
    logic               slow_clk_q;
    logic               slow_clk_d;
    logic               slow_tick_q;
    logic               slow_tick_d;

    pb_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_pb_up (
        .clk    (CLK_50),
        .rst_n  (reset),
        .pb_i   (pb_freq_up),
        .step_o (up_step)
    );

    pb_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_pb_dn (
        .clk    (CLK_50),
        .rst_n  (reset),
        .pb_i   (pb_freq_dn),
        .step_o (dn_step)
    );

    assign step = step_e'({dn_step, up_step});

    always_comb begin
        freq_num_d = freq_num_q;
        case (step)
            STEP_UP: if (freq_num_q != TOP_LEVEL) freq_num_d = freq_num_q + LEVEL_W'(1);
            STEP_DN: if (freq_num_q != '0)        freq_num_d = freq_num_q - LEVEL_W'(1);
            default: freq_num_d = freq_num_q;
        endcase
    end

    assign half_m1 = CNT_W'(half_period(MAX_SHIFT, 32'(active_level_q)) - 32'd1);

    always_comb begin
        div_cnt_d      = div_cnt_q + CNT_W'(1);
        slow_clk_d     = slow_clk_q;
        slow_tick_d    = 1'b0;
        active_level_d = active_level_q;
        if (div_cnt_q == half_m1) begin
            div_cnt_d   = '0;
            slow_clk_d  = ~slow_clk_q;
            slow_tick_d = ~slow_clk_q;
            // New rate takes effect only on a falling edge, so each low/high pair shares one length.
            if (slow_clk_q) active_level_d = freq_num_q;
        end
    end

    always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            freq_num_q     <= INIT_LEVEL;
            active_level_q <= INIT_LEVEL;
            div_cnt_q      <= '0;
            slow_clk_q     <= 1'b0;
            slow_tick_q    <= 1'b0;
        end else begin
            freq_num_q     <= freq_num_d;
            active_level_q <= active_level_d;
            div_cnt_q      <= div_cnt_d;
            slow_clk_q     <= slow_clk_d;
            slow_tick_q    <= slow_tick_d;
        end
    end

    assign slow_clk  = slow_clk_q;
    assign slow_tick = slow_tick_q;
    assign freq_num  = freq_num_q;
    assign at_max    = (freq_num_q == TOP_LEVEL);
    assign at_min    = (freq_num_q == '0);

endmodule

// File: tb/tb_throttle_ctrl.sv
// tb/tb_throttle_ctrl.sv - self-checking bench for throttle_ctrl (repeat checks when THROTTLE_AUTOREPEAT_EN is defined)
module tb_throttle_ctrl;

    localparam int NL = 4;
    localparam int LW = 2;
    localparam int MS = 4;
    localparam int DB = 4;
    localparam int HC = 20;
    localparam int RC = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          up    = 1'b0;
    logic          dn    = 1'b0;
    logic          slow_clk;
    logic          slow_tick;
    logic [LW-1:0] freq_num;
    logic          at_max;
    logic          at_min;

    int   total = 0;
    int   bad   = 0;
    int   exp_lvl = 0;
    logic mon_en = 1'b0;

    int            ticks;
    int            n;
    int            m;
    int            nchg;
    int            kind;
    int            hold;
    int            gap;
    int            chg_t [4];
    logic [LW-1:0] prevf;
    logic          u;

    always #5 clk = ~clk;

    throttle_ctrl #(
        .NUM_LEVELS      (NL),
        .LEVEL_W         (LW),
        .MAX_SHIFT       (MS),
        .RESET_LEVEL     (0),
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (HC),
        .REPEAT_CYCLES   (RC)
    ) dut (
        .CLK_50     (clk),
        .reset      (rst_n),
        .pb_freq_up (up),
        .pb_freq_dn (dn),
        .slow_clk   (slow_clk),
        .slow_tick  (slow_tick),
        .freq_num   (freq_num),
        .at_max     (at_max),
        .at_min     (at_min)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic chk_level(input string tag);
        chk({tag, "_freq"}, freq_num, exp_lvl);
        chk({tag, "_at_max"}, at_max, (exp_lvl == NL - 1));
        chk({tag, "_at_min"}, at_min, (exp_lvl == 0));
    endtask

    task automatic wait_toggle(output int cnt);
        logic v;
        v   = slow_clk;
        cnt = 0;
        do begin
            step(1);
            cnt++;
        end while (slow_clk === v && cnt < 100);
        chk("toggle_timeout", (slow_clk === v), 0);
    endtask

    // Waits for the next falling edge and measures the low phase that follows.
    task automatic expect_low(input string tag, input int exp);
        int c;
        wait_toggle(c);
        if (slow_clk !== 1'b0) wait_toggle(c);
        wait_toggle(c);
        chk(tag, c, exp);
    endtask

    // Model: a press counts only when held at least DB cycles; saturating, both-at-once ignored.
    task automatic press(input logic pu, input logic pd, input int h, input int g);
        up = pu;
        dn = pd;
        step(h);
        up = 1'b0;
        dn = 1'b0;
        step(g);
        if (h >= DB) begin
            if (pu && !pd && exp_lvl < NL - 1) exp_lvl = exp_lvl + 1;
            else if (pd && !pu && exp_lvl > 0) exp_lvl = exp_lvl - 1;
        end
    endtask

    logic m_started  = 1'b0;
    logic m_prev     = 1'b0;
    logic m_valid    = 1'b0;
    logic m_have_low = 1'b0;
    int   m_len      = 0;
    int   m_low      = 0;

    always @(negedge clk) begin
        if (!mon_en) begin
            m_started  = 1'b0;
            m_valid    = 1'b0;
            m_have_low = 1'b0;
        end else if (!m_started) begin
            m_started = 1'b1;
            m_prev    = slow_clk;
            m_len     = 0;
        end else begin
            chk("mon_tick_on_rise", slow_tick, (slow_clk === 1'b1 && m_prev === 1'b0));
            if (slow_clk !== m_prev) begin
                if (m_valid && m_prev && m_have_low) chk("mon_high_eq_low", m_len, m_low);
                if (m_valid && !m_prev) begin
                    m_low      = m_len;
                    m_have_low = 1'b1;
                end
                m_valid = 1'b1;
                m_len   = 1;
            end else begin
                m_len++;
            end
            m_prev = slow_clk;
        end
    end

    initial begin
        step(3);
        chk("rst_slow_clk", slow_clk, 0);
        chk("rst_slow_tick", slow_tick, 0);
        exp_lvl = 0;
        chk_level("rst");

        rst_n  = 1'b1;
        mon_en = 1'b1;
        step(15);
        chk("t1_low_16", slow_clk, 0);
        step(1);
        chk("t1_rise_16", slow_clk, 1);
        chk("t1_tick_at_rise", slow_tick, 1);
        ticks = 0;
        for (int i = 0; i < 64; i++) begin
            step(1);
            ticks += int'(slow_tick);
        end
        chk("t1_ticks_per_64", ticks, 2);

        up = 1'b1;
        step(3);
        up = 1'b0;
        step(20);
        chk("t2_glitch", freq_num, 0);
        up = 1'b1;
        n  = 0;
        do begin
            step(1);
            n++;
        end while (freq_num == 0 && n < 40);
        chk("t2_latency", n, 8);
        step(n < 10 ? 10 - n : 0);
        up = 1'b0;
        step(14);
        exp_lvl = 1;
        chk_level("t2_one_step");
        expect_low("t2_low_after_step", 8);

        for (int i = 0; i < 4; i++) begin
            press(1'b1, 1'b0, 10, 12);
            chk_level($sformatf("t3_up%0d", i));
        end
        for (int i = 0; i < 5; i++) begin
            press(1'b0, 1'b1, 10, 12);
            chk_level($sformatf("t3_dn%0d", i));
        end

        press(1'b1, 1'b0, 10, 12);
        press(1'b1, 1'b1, 10, 12);
        chk_level("t4_both");
        expect_low("t4_low", 8);
        wait_toggle(m);
        chk("t4_high", m, 8);

        press(1'b0, 1'b1, 10, 12);
        expect_low("t5_settle_low", 16);
        step(2);
        up = 1'b1;
        step(8);
        up = 1'b0;
        wait_toggle(m);
        chk("t5_high_kept", 10 + m, 16);
        wait_toggle(m);
        chk("t5_new_low", m, 8);
        exp_lvl = 1;
        chk_level("t5_level");

        wait_toggle(m);
        wait_toggle(m);
        step(3);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("t6_async_slow_clk", slow_clk, 0);
        chk("t6_async_tick", slow_tick, 0);
        exp_lvl = 0;
        chk_level("t6_async");
        up = 1'b1;
        step(2);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step(20);
        chk_level("t6_held_through_reset");
        up = 1'b0;
        step(12);

        up    = 1'b1;
        nchg  = 0;
        prevf = freq_num;
        for (int i = 1; i <= 60; i++) begin
            step(1);
            if (freq_num !== prevf) begin
                if (nchg < 4) chg_t[nchg] = i;
                nchg++;
                prevf = freq_num;
            end
        end
        up = 1'b0;
        step(14);
`ifdef THROTTLE_AUTOREPEAT_EN
        chk("t6_rep_count", nchg, 3);
        chk("t6_rep_t0", chg_t[0], 8);
        chk("t6_rep_t1", chg_t[1], 8 + HC);
        chk("t6_rep_t2", chg_t[2], 8 + HC + RC);
        exp_lvl = NL - 1;
`else
        chk("t6_single_count", nchg, 1);
        chk("t6_single_t0", chg_t[0], 8);
        exp_lvl = 1;
`endif
        chk_level("t6_after_hold");

        for (int k = 0; k < 16; k++) begin
            kind = $urandom_range(0, 5);
            hold = $urandom_range(6, 14);
            gap  = $urandom_range(8, 16);
            case (kind)
                0, 1: press(1'b1, 1'b0, hold, gap);
                2, 3: press(1'b0, 1'b1, hold, gap);
                4:    press(1'b1, 1'b1, hold, gap);
                default: begin
                    u = 1'($urandom_range(0, 1));
                    press(u, !u, $urandom_range(1, DB - 1), gap);
                end
            endcase
            chk_level($sformatf("rnd%0d_k%0d", k, kind));
        end
        expect_low("rnd_final_half", 1 << (MS - exp_lvl));

        step(5);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
